// File: rtl/seq_decoder_pkg.sv
// Shared types and helpers for the seq_decoder block.
// State encoding and the constant log2 used to size the scan dwell counter.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  // Smallest r with 2**r >= value; evaluated at elaboration only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_decoder_if.sv
// Handshake bundle between the index producer, seq_decoder and the line consumer.
// slave is the decoder side, master is the side that drives indices and consumes lines.
interface seq_decoder_if #(
  parameter int SEL_W = 2
) ();
  localparam int OUT_W = 1 << SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic [SEL_W-1:0] out_idx;
  logic             scan_wrap;

  modport slave (
    input  in_valid, in_sel, out_ready,
    output in_ready, out_valid, out_onehot, out_idx, scan_wrap
  );

  modport master (
    output in_valid, in_sel, out_ready,
    input  in_ready, out_valid, out_onehot, out_idx, scan_wrap
  );
endinterface

// File: rtl/seq_decoder_onehot_dec.sv
// Combinational index-to-line decoder with selectable output polarity.
// All lines are inactive when valid_i is low.
module onehot_dec #(
  parameter int SEL_W      = 2,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [SEL_W-1:0]        idx_i,
  input  logic                    valid_i,
  output logic [(1<<SEL_W)-1:0]   onehot_o
);
  localparam int OUT_W = 1 << SEL_W;

  logic [OUT_W-1:0] raw;

  // Build the active-high pattern, then apply polarity.
  always_comb begin
    raw        = '0;
    raw[idx_i] = valid_i;
    onehot_o   = ACTIVE_LOW ? ~raw : raw;
  end
endmodule

// File: rtl/seq_decoder.sv
// Registered binary-to-one-hot decoder with valid/ready handshake.
// Optional walking-line scan mode is built only when DECODER_SCAN_EN is defined;
// without it, mode is ignored and scan_wrap is tied low.
//
// state | meaning
// IDLE  | no live output, out_valid=0
// HOLD  | decoded index presented until popped
// SCAN  | walking line, each index held DWELL cycles
module seq_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mode,
  seq_decoder_if.slave  bus
);
  localparam int               OUT_W      = 1 << SEL_W;
  localparam logic [OUT_W-1:0] IDLE_LINES = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] onehot_q, onehot_d;
  logic             wrap_q, wrap_d;
  logic             scan_req;
  logic             accept;
  logic             pop;

`ifdef DECODER_SCAN_EN
  localparam int                 DWELL_W    = clog2(DWELL + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  logic [DWELL_W-1:0] dwell_q, dwell_d;

  assign scan_req = mode;
`else
  logic unused_cfg;

  assign scan_req   = 1'b0;
  assign unused_cfg = mode ^ (DWELL > 0);
`endif

  // Refusing input while still in SCAN keeps an index from being dropped
  // during the one cycle spent leaving scan.
  assign bus.in_ready = en && !scan_req && (state_q != SCAN) && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = valid_q && bus.out_ready;

  // Next-state logic: decode handshake, scan walk and mode changes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
`ifdef DECODER_SCAN_EN
    dwell_d = dwell_q;
`endif
    if (en) begin
`ifdef DECODER_SCAN_EN
      if (scan_req) begin
        if (state_q != SCAN) begin
          state_d = SCAN;
          idx_d   = '0;
          valid_d = 1'b1;
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          idx_d   = idx_q + 1'b1;
          wrap_d  = (idx_q == {SEL_W{1'b1}});
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end else if (state_q == SCAN) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end else
`endif
      if (accept) begin
        state_d = HOLD;
        idx_d   = bus.in_sel;
        valid_d = 1'b1;
      end else if (pop) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    end
  end

  onehot_dec #(
    .SEL_W      (SEL_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_onehot_dec (
    .idx_i    (idx_d),
    .valid_i  (valid_d),
    .onehot_o (onehot_d)
  );

  // State and output registers; reset drops any pending output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      onehot_q <= IDLE_LINES;
      wrap_q   <= 1'b0;
`ifdef DECODER_SCAN_EN
      dwell_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      onehot_q <= onehot_d;
      wrap_q   <= wrap_d;
`ifdef DECODER_SCAN_EN
      dwell_q  <= dwell_d;
`endif
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;
  assign bus.scan_wrap  = wrap_q;
endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: scoreboard on the SEL_W=2 active-high
// instance, directed checks on a SEL_W=3 active-low instance. Scan checks are
// compiled only when DECODER_SCAN_EN is defined.
module tb_seq_decoder;
  logic clk;
  logic rst_n;
  logic en;
  logic mode;

  int n_cmp;
  int n_err;

  seq_decoder_if #(.SEL_W(2)) bus_a ();
  seq_decoder_if #(.SEL_W(3)) bus_b ();

  seq_decoder #(.SEL_W(2), .DWELL(2), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .bus   (bus_a)
  );

  seq_decoder #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .bus   (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard for dut_a: entries are the indices expected to be presented
  logic [1:0] exp_q[$];
  logic       mon_on;
  logic       m_valid;
  logic       m_ready;
  logic       m_mode;

  always @(negedge clk) begin
    if (mon_on) begin
`ifdef DECODER_SCAN_EN
      m_mode = mode;
`else
      m_mode = 1'b0;
`endif
      m_valid = (exp_q.size() != 0);
      m_ready = en && !m_mode && (!m_valid || bus_a.out_ready);
      chk("a_out_valid", bus_a.out_valid, m_valid);
      chk("a_in_ready", bus_a.in_ready, m_ready);
      chk("a_scan_wrap", bus_a.scan_wrap, 1'b0);
      if (m_valid) begin
        chk("a_out_idx", bus_a.out_idx, exp_q[0]);
        chk("a_onehot", bus_a.out_onehot, 32'd1 << exp_q[0]);
      end else begin
        chk("a_onehot_idle", bus_a.out_onehot, 4'b0000);
      end
      if (en && m_valid && bus_a.out_ready) void'(exp_q.pop_front());
      if (m_ready && bus_a.in_valid) exp_q.push_back(bus_a.in_sel);
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    mon_on = 1'b0;
    rst_n = 1'b0;
    en = 1'b1;
    mode = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_a.in_sel = '0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0;
    bus_b.in_sel = '0;
    bus_b.out_ready = 1'b0;

    // reset values
    #12;
    chk("rst_out_valid", bus_a.out_valid, 1'b0);
    chk("rst_onehot", bus_a.out_onehot, 4'b0000);
    chk("rst_out_idx", bus_a.out_idx, 2'd0);
    chk("rst_in_ready", bus_a.in_ready, 1'b1);
    chk("rst_scan_wrap", bus_a.scan_wrap, 1'b0);
    chk("rst_b_onehot", bus_b.out_onehot, 8'hFF);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 mon_on = 1'b1;

    // back-to-back decode 0..3
    for (int s = 0; s < 4; s++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_sel = 2'(s);
      bus_a.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus_a.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // back-pressure: 2 held while out_ready low, 1 waits
    bus_a.in_valid = 1'b1;
    bus_a.in_sel = 2'd2;
    bus_a.out_ready = 1'b0;
    @(posedge clk); #1;
    bus_a.in_sel = 2'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_onehot_held", bus_a.out_onehot, 4'b0100);
      chk("bp_in_ready", bus_a.in_ready, 1'b0);
    end
    @(posedge clk); #1 bus_a.out_ready = 1'b1;
    @(posedge clk); #1 bus_a.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_onehot", bus_a.out_onehot, 4'b0010);
    @(posedge clk); #1;

    // random traffic including en gaps (and ignored mode without scan)
    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(0, 7) != 0);
`ifdef DECODER_SCAN_EN
      mode = 1'b0;
`else
      mode = $urandom_range(0, 1);
`endif
      bus_a.in_valid = $urandom_range(0, 1);
      bus_a.in_sel = 2'($urandom_range(0, 3));
      bus_a.out_ready = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    en = 1'b1;
    mode = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    mon_on = 1'b0;

    // active-low, SEL_W=3: index 5
    bus_b.in_valid = 1'b1;
    bus_b.in_sel = 3'd5;
    @(posedge clk); #1 bus_b.in_valid = 1'b0;
    @(negedge clk);
    chk("b_onehot_5", bus_b.out_onehot, 8'b11011111);
    chk("b_out_valid", bus_b.out_valid, 1'b1);
    @(posedge clk); #1 bus_b.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_onehot_idle", bus_b.out_onehot, 8'hFF);
    chk("b_out_valid_idle", bus_b.out_valid, 1'b0);

    // HOLD with index 3 pending
    bus_a.in_valid = 1'b1;
    bus_a.in_sel = 2'd3;
    bus_a.out_ready = 1'b0;
    @(posedge clk); #1 bus_a.in_valid = 1'b0;
    @(negedge clk);
    chk("hold_idx3", bus_a.out_idx, 2'd3);
    chk("hold_onehot3", bus_a.out_onehot, 4'b1000);

`ifdef DECODER_SCAN_EN
    // switch to scan: 0,0,1,1,2,2,3,3,0 with wrap on the last
    @(posedge clk); #1 mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1 bus_a.out_ready = $urandom_range(0, 1);
      @(negedge clk);
      chk("scan_idx", bus_a.out_idx, (i / 2) % 4);
      chk("scan_valid", bus_a.out_valid, 1'b1);
      chk("scan_wrap", bus_a.scan_wrap, (i == 8));
      chk("scan_in_ready", bus_a.in_ready, 1'b0);
    end
    @(posedge clk); #1;
`endif

    // asynchronous reset mid-operation
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus_a.out_valid, 1'b0);
    chk("arst_out_idx", bus_a.out_idx, 2'd0);
    chk("arst_onehot", bus_a.out_onehot, 4'b0000);
    chk("arst_scan_wrap", bus_a.scan_wrap, 1'b0);
    #4 rst_n = 1'b1;
    mode = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus_a.in_ready, 1'b1);
    chk("post_rst_valid", bus_a.out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_decoder.md
# seq_decoder

Parametrised, registered binary-to-one-hot decoder with a valid/ready handshake and an optional free-running scan mode. It generalises the two-input, four-output combinational decoder to SEL_W select bits, and adds selectable output polarity, a one-entry output register with back-pressure, and a walking-line scan for display and row multiplexing. It sits between control logic issuing line indices and the enable/strobe lines of downstream devices.

## Interface
- SEL_W, 2: select width; OUT_W = 2**SEL_W (localparam, not overridable).
- DWELL, 4: cycles each line stays active in scan mode; legal range 1 to 65535.
- ACTIVE_LOW, 0: 1 means the active line is driven 0 and all inactive lines are driven 1.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  global enable; when 0, all state holds and in_ready=0.
- mode  input  1  0 = decode, 1 = scan (scan only with DECODER_SCAN_EN).
- in_valid  input  1  in_sel is valid.
- in_ready  output  1  block accepts in_sel this cycle.
- in_sel  input  SEL_W  line index to assert.
- out_valid  output  1  out_onehot/out_idx hold a live value.
- out_ready  input  1  consumer accepts the output (decode mode only).
- out_onehot  output  OUT_W  decoded lines: bit k active iff out_valid && out_idx==k.
- out_idx  output  SEL_W  index currently presented.
- scan_wrap  output  1  one-cycle pulse when scan wraps from OUT_W-1 to 0.

## Operation
- States: IDLE (out_valid=0), HOLD (decode result presented), SCAN.
- Reset: state IDLE, out_valid=0, out_idx=0, out_onehot all inactive (0s, or 1s if ACTIVE_LOW), scan_wrap=0, dwell counter 0. Reset applies mid-operation at any time and drops the pending output.
- Decode mode:
  - in_ready = en && !mode && (!out_valid || out_ready).
  - Accept when in_valid && in_ready: next state HOLD, out_idx=in_sel.
  - Pop when out_valid && out_ready: with no simultaneous accept, go to IDLE.
  - Simultaneous accept and pop: stay in HOLD with the new index, out_valid stays 1 with no bubble.
  - While held, the output stays stable until popped.
- Scan mode (en=1, mode=1):
  - in_ready=0 and out_ready is ignored.
  - out_valid=1 and out_idx walks 0,1,…,OUT_W-1,0,…; each index is held DWELL cycles.
  - scan_wrap=1 in the first cycle of index 0 after index OUT_W-1. There is no pulse on the initial entry to scan.
- Mode change (mode differs from the current state's mode, sampled with en=1):
  - Any mode to scan: the next cycle enters SCAN at idx 0 with the dwell counter cleared. A pending HOLD value is discarded.
  - SCAN to decode: the next cycle goes to IDLE with out_valid=0.
- en=0: all registers hold, including the dwell counter. Outputs stay frozen; scan_wrap is forced to 0.

## Timing
- Decode latency: 1 cycle from accept to out_valid.
- Throughput: 1 index per cycle under continuous out_ready.
- All outputs are registered except in_ready, which is combinational from out_valid, out_ready, en and mode.
- DWELL=1: the index advances every cycle, and scan_wrap fires every OUT_W cycles.
- The dwell counter is a DWELL_W = clog2(DWELL+1)-bit counter; it resets to 0 on each index advance.

## Configuration
- DECODER_SCAN_EN defined: the SCAN state, dwell counter and scan_wrap logic are present, as described above.
- DECODER_SCAN_EN not defined:
  - mode is ignored and treated as 0, so the block operates in decode mode only.
  - scan_wrap is tied to 0.
  - The dwell counter and SCAN state are not built.

## Structure
- Package decoder_pkg holds:
  - the state encoding (IDLE=0, HOLD=1, SCAN=2);
  - the clog2 constant function used to size DWELL_W.
- Sub-module onehot_dec (parameters SEL_W, ACTIVE_LOW) is purely combinational. It maps idx and valid to out_onehot with polarity applied, and its output feeds the out_onehot register.

## Test plan
- Reset with ACTIVE_LOW=0, SEL_W=2, en=1, mode=0: out_valid=0, out_onehot=4'b0000, out_idx=0, in_ready=1.
- Decode back-to-back (SEL_W=2, mode=0, en=1, in_valid=1, out_ready=1), indices 0,1,2,3 on consecutive cycles -> out_onehot 0001, 0010, 0100, 1000 on the following four cycles, with no bubble.
- Back-pressure: accept 2 with out_ready=0 for 3 cycles -> out_onehot=0100 held, in_ready=0, second index not accepted until out_ready=1.
- Scan (macro defined, DWELL=2, SEL_W=2): out_idx sequence 0,0,1,1,2,2,3,3,0 -> scan_wrap high only on the cycle idx returns to 0; out_ready=0 has no effect.
- ACTIVE_LOW=1, SEL_W=3, decode index 5 -> out_onehot=8'b11011111; when idle -> 8'hFF.
- Mode switch while in HOLD with idx 3 pending: mode=1 -> next cycle out_idx=0, dwell restarts. Then assert rst_n=0 mid-scan -> outputs return to reset values immediately.
